// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One transaction in flight: IDLE accepts, ISSUE drives the ALU, RESP holds the result.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  input  logic [63:0] req0_a,
  input  logic [63:0] req1_a,
  input  logic [1:0]  req0_bsel,
  input  logic [1:0]  req1_bsel,
  input  logic [63:0] req0_rs2,
  input  logic [63:0] req1_rs2,
  input  logic [63:0] req0_imm,
  input  logic [63:0] req1_imm,
  output logic [3:0]  alu_op,
  output logic [63:0] alu_a,
  output logic [1:0]  alu_bsel,
  output logic [63:0] alu_rs2,
  output logic [63:0] alu_imm,
  input  logic [63:0] alu_res,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [1:0]  bsel;
    logic [63:0] rs2;
    logic [63:0] imm;
  } opnd_t;

  state_t state;
  state_t state_nxt;
  opnd_t  opnd;
  opnd_t  req0_opnd;
  opnd_t  req1_opnd;
  logic   gnt;
  logic   last;
  logic   win;
  logic   accept;

  assign req0_opnd = {req0_op, req0_a, req0_bsel, req0_rs2, req0_imm};
  assign req1_opnd = {req1_op, req1_a, req1_bsel, req1_rs2, req1_imm};
  assign accept    = (state == IDLE) && (|req_valid);

  // On contention the requester not granted last time wins.
  always_comb begin
    win = 1'b0;
    unique case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (state != IDLE);
    {alu_op, alu_a, alu_bsel, alu_rs2, alu_imm} = '0;
    if (accept) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
    if (state != IDLE) begin
      {alu_op, alu_a, alu_bsel, alu_rs2, alu_imm} = opnd;
    end
    if (state == RESP) begin
      rsp_valid = gnt ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd     <= '0;
      gnt      <= 1'b0;
      last     <= 1'b1;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        opnd <= win ? req1_opnd : req0_opnd;
        gnt  <= win;
        last <= win;
      end
      if (state == ISSUE) begin
        rsp_data <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a
// result scoreboard filled at issue and drained at response.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req0_op, req1_op;
  logic [63:0] req0_a, req1_a;
  logic [1:0]  req0_bsel, req1_bsel;
  logic [63:0] req0_rs2, req1_rs2;
  logic [63:0] req0_imm, req1_imm;
  logic [3:0]  alu_op;
  logic [63:0] alu_a;
  logic [1:0]  alu_bsel;
  logic [63:0] alu_rs2;
  logic [63:0] alu_imm;
  logic [63:0] alu_res;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic        busy;

  typedef struct packed {
    logic [1:0]  vld;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;
  int   n_fail;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .req0_a    (req0_a),
    .req1_a    (req1_a),
    .req0_bsel (req0_bsel),
    .req1_bsel (req1_bsel),
    .req0_rs2  (req0_rs2),
    .req1_rs2  (req1_rs2),
    .req0_imm  (req0_imm),
    .req1_imm  (req1_imm),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_bsel  (alu_bsel),
    .alu_rs2   (alu_rs2),
    .alu_imm   (alu_imm),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(
    input logic [3:0]  op,
    input logic [63:0] a,
    input logic [1:0]  bsel,
    input logic [63:0] rs2,
    input logic [63:0] imm
  );
    logic [63:0] b;
    b = (bsel == 2'b01) ? rs2 : (bsel == 2'b10) ? imm : 64'd0;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res = ref_alu(alu_op, alu_a, alu_bsel, alu_rs2, alu_imm);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] op,
                         input logic [63:0] a, input logic [1:0] bsel,
                         input logic [63:0] rs2, input logic [63:0] imm);
    if (idx == 0) begin
      req0_op = op; req0_a = a; req0_bsel = bsel;
      req0_rs2 = rs2; req0_imm = imm;
    end else begin
      req1_op = op; req1_a = a; req1_bsel = bsel;
      req1_rs2 = rs2; req1_imm = imm;
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    e = '0;
    chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(e.vld));
    chk({tag, "_rsp_data"}, rsp_data, e.data);
  endtask

  // Single request with rsp_ready held high: accept, ISSUE, RESP, IDLE.
  task automatic run_txn(input string tag, input int idx,
                         input logic [3:0] op, input logic [63:0] a,
                         input logic [1:0] bsel, input logic [63:0] rs2,
                         input logic [63:0] imm);
    logic [1:0] oh;
    oh = (idx == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    set_req(idx, op, a, bsel, rs2, imm);
    req_valid = oh;
    #1;
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(oh));
    sb.push_back('{vld: oh, data: ref_alu(op, a, bsel, rs2, imm)});
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk({tag, "_issue_busy"}, 64'(busy), 64'd1);
    chk({tag, "_issue_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_op), 64'(op));
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_bsel"}, 64'(alu_bsel), 64'(bsel));
    chk({tag, "_alu_rs2"}, alu_rs2, rs2);
    chk({tag, "_alu_imm"}, alu_imm, imm);
    @(negedge clk);
    #1;
    pop_chk(tag);
    @(negedge clk);
    #1;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_rsp"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] hold;
    logic [1:0]  oh;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    set_req(0, 4'd0, 64'd0, 2'b00, 64'd0, 64'd0);
    set_req(1, 4'd0, 64'd0, 2'b00, 64'd0, 64'd0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    rsp_ready = 2'b11;

    // ADD 5 + rs2 7 from requester 0.
    run_txn("add", 0, 4'd0, 64'd5, 2'b01, 64'd7, 64'd0);
    chk("add_value", rsp_data, 64'd12);

    // Contention from reset: grants 0,1,0,1 every 3 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_req(0, 4'd0, 64'd100, 2'b01, 64'd1, 64'd0);
    set_req(1, 4'd1, 64'd50, 2'b10, 64'd0, 64'd8);
    d0 = ref_alu(4'd0, 64'd100, 2'b01, 64'd1, 64'd0);
    d1 = ref_alu(4'd1, 64'd50, 2'b10, 64'd0, 64'd8);
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      #1;
      oh = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr_req_ready_%0d", k), 64'(req_ready),
          (k % 3 == 0) ? 64'(oh) : 64'd0);
      if (k % 3 == 0) begin
        sb.push_back('{vld: oh, data: (oh == 2'b01) ? d0 : d1});
      end
      if (k % 3 == 2) pop_chk($sformatf("rr_rsp_%0d", k));
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Immediate operand and forwarded zero select, requester 1.
    run_txn("imm", 1, 4'd0, 64'h10, 2'b10, 64'd9,
            64'hFFFF_FFFF_FFFF_FFF0);
    run_txn("zsel", 1, 4'd0, 64'd3, 2'b11, 64'd9, 64'h55);

    // Response backpressure with new requests pending.
    @(negedge clk);
    rsp_ready = 2'b00;
    set_req(0, 4'd2, 64'hF0, 2'b01, 64'h0F, 64'd0);
    hold = ref_alu(4'd2, 64'hF0, 2'b01, 64'h0F, 64'd0);
    req_valid = 2'b01;
    #1;
    chk("bp_req_ready", 64'(req_ready), 64'd1);
    sb.push_back('{vld: 2'b01, data: hold});
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    pop_chk("bp_first");
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data", rsp_data, hold);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_release_rsp", 64'(rsp_valid), 64'd0);
    chk("bp_release_ready", 64'(req_ready), 64'd2);
    req_valid = 2'b00;

    // Reset during ISSUE drops the transaction and re-arms last.
    @(negedge clk);
    rsp_ready = 2'b11;
    set_req(0, 4'd0, 64'd1, 2'b01, 64'd1, 64'd0);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("mid_issue_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
    chk("mid_rst_alu_a", alu_a, 64'd0);
    chk("mid_rst_alu_bsel", 64'(alu_bsel), 64'd0);
    chk("mid_rst_alu_rs2", alu_rs2, 64'd0);
    chk("mid_rst_alu_imm", alu_imm, 64'd0);
    chk("mid_rst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end
    @(negedge clk);
    set_req(0, 4'd3, 64'hFF00, 2'b10, 64'd0, 64'h0FF0);
    set_req(1, 4'd0, 64'd1, 2'b01, 64'd1, 64'd0);
    req_valid = 2'b11;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'd1);
    sb.push_back('{vld: 2'b01,
                   data: ref_alu(4'd3, 64'hFF00, 2'b10, 64'd0, 64'h0FF0)});
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    pop_chk("post_rst_rsp");
    @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
